// File: rtl/theremin_audio_pkg.sv
// Shared audio types and FSM states for the theremin audio frame feeder.
package theremin_audio_pkg;

  localparam int AUDIO_SAMPLE_W = 24;

  typedef logic [AUDIO_SAMPLE_W-1:0] audio_sample_t;

  typedef struct packed {
    audio_sample_t left0;
    audio_sample_t right0;
    audio_sample_t left1;
    audio_sample_t right1;
  } audio_frame_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACKS   = 2'd2,
    WAITLO = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/theremin_audio_frame_fifo.sv
// DEPTH-entry stereo frame FIFO; a push while full is taken only when a pop shares the cycle.
module theremin_audio_frame_fifo
  import theremin_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push_i,
  input  audio_frame_t           push_dat_i,
  input  logic                   pop_i,
  output audio_frame_t           pop_dat_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  audio_frame_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/theremin_audio_frame_feeder.sv
// Feeds buffered stereo frames to the audio I/O stage on each IRQ rise and captures Line In.
// Define THEREMIN_AUDIO_HOLD_ON_UNDERRUN_EN to hold the previous frame on underrun instead of zeroing.
module theremin_audio_frame_feeder
  import theremin_audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  logic [AUDIO_SAMPLE_W-1:0] S_LEFT0,
  input  logic [AUDIO_SAMPLE_W-1:0] S_RIGHT0,
  input  logic [AUDIO_SAMPLE_W-1:0] S_LEFT1,
  input  logic [AUDIO_SAMPLE_W-1:0] S_RIGHT1,
  input  logic                      IRQ,
  output logic                      ACK,
  output logic [AUDIO_SAMPLE_W-1:0] OUT_LEFT_CHANNEL0,
  output logic [AUDIO_SAMPLE_W-1:0] OUT_RIGHT_CHANNEL0,
  output logic [AUDIO_SAMPLE_W-1:0] OUT_LEFT_CHANNEL1,
  output logic [AUDIO_SAMPLE_W-1:0] OUT_RIGHT_CHANNEL1,
  input  logic [AUDIO_SAMPLE_W-1:0] IN_LEFT_CHANNEL,
  input  logic [AUDIO_SAMPLE_W-1:0] IN_RIGHT_CHANNEL,
  output logic                      CAP_VALID,
  output logic [AUDIO_SAMPLE_W-1:0] CAP_LEFT,
  output logic [AUDIO_SAMPLE_W-1:0] CAP_RIGHT,
  output logic [$clog2(DEPTH):0]    LEVEL,
  output logic [15:0]               UNDERRUN_COUNT
);

  localparam bit DEPTH_OK = (DEPTH >= 2) && (DEPTH <= 64) && ((DEPTH & (DEPTH - 1)) == 0);

  generate
    if (!DEPTH_OK) begin : g_bad_depth
      $error("theremin_audio_frame_feeder: DEPTH must be a power of two from 2 to 64");
    end
  endgenerate

  feeder_state_t state_q, state_d;
  logic          irq_q, irq_prev_q;
  audio_frame_t  out_q, out_d;
  audio_sample_t cap_left_q, cap_right_q;
  logic          cap_vld_q;
  logic [15:0]   underrun_q;

  audio_frame_t  push_frame, head_frame;
  logic          fifo_full, fifo_empty, fifo_pop, in_load;

  assign push_frame = '{left0: S_LEFT0, right0: S_RIGHT0, left1: S_LEFT1, right1: S_RIGHT1};
  assign in_load    = (state_q == LOAD);
  // Level is registered, so a frame pushed during an empty LOAD is never popped in that LOAD.
  assign fifo_pop   = in_load && !fifo_empty;

  theremin_audio_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RESET      (RESET),
    .push_i     (S_VALID),
    .push_dat_i (push_frame),
    .pop_i      (fifo_pop),
    .pop_dat_o  (head_frame),
    .level_o    (LEVEL),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign S_READY = !fifo_full;
  assign ACK     = (state_q == ACKS);

  // IRQ is sampled once before edge detection, giving three edges from IRQ rise to ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (irq_q && !irq_prev_q) state_d = LOAD;
      LOAD:    state_d = ACKS;
      ACKS:    state_d = WAITLO;
      WAITLO:  if (!IRQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (in_load) begin
      if (!fifo_empty) begin
        out_d = head_frame;
      end else begin
`ifdef THEREMIN_AUDIO_HOLD_ON_UNDERRUN_EN
        out_d = out_q;
`else
        out_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      irq_q       <= 1'b0;
      irq_prev_q  <= 1'b0;
      out_q       <= '0;
      cap_left_q  <= '0;
      cap_right_q <= '0;
      cap_vld_q   <= 1'b0;
      underrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= IRQ;
      irq_prev_q <= irq_q;
      out_q      <= out_d;
      cap_vld_q  <= in_load;
      if (in_load) begin
        cap_left_q  <= IN_LEFT_CHANNEL;
        cap_right_q <= IN_RIGHT_CHANNEL;
      end
      if (in_load && fifo_empty && (underrun_q != 16'hFFFF)) underrun_q <= underrun_q + 16'd1;
    end
  end

  assign OUT_LEFT_CHANNEL0  = out_q.left0;
  assign OUT_RIGHT_CHANNEL0 = out_q.right0;
  assign OUT_LEFT_CHANNEL1  = out_q.left1;
  assign OUT_RIGHT_CHANNEL1 = out_q.right1;
  assign CAP_VALID          = cap_vld_q;
  assign CAP_LEFT           = cap_left_q;
  assign CAP_RIGHT          = cap_right_q;
  assign UNDERRUN_COUNT     = underrun_q;

endmodule
